// File: rtl/rvx_wb_bridge_pkg.sv
// Shared types and constants for the rvx_core to Wishbone B4 bridge.
package rvx_wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    localparam int RESP_STAGES_MAX = 4;

endpackage

// File: rtl/rvx_wb_bridge_resp_pipe.sv
// Delay line for the {valid, err, data} response bundle.
module resp_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bundle,
    output logic [WIDTH-1:0] delayed
);

    if (DEPTH == 0) begin : g_pass
        assign delayed = bundle;
    end else begin : g_regs
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= bundle;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign delayed = stage[DEPTH-1];
    end

endmodule

// File: rtl/rvx_wb_bridge.sv
// Bridge from the rvx_core request/response port to a pipelined Wishbone B4 master.
module rvx_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RESP_STAGES    = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic [ADDR_WIDTH-1:0]   core_address,
    input  logic                    core_read_request,
    input  logic                    core_write_request,
    input  logic [DATA_WIDTH-1:0]   core_write_data,
    input  logic [DATA_WIDTH/8-1:0] core_write_strobe,
    output logic [DATA_WIDTH-1:0]   core_read_data,
    output logic                    core_read_response,
    output logic                    core_write_response,
    output logic                    core_error,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    import rvx_wb_bridge_pkg::*;

    if (DATA_WIDTH % 8 != 0 || RESP_STAGES > RESP_STAGES_MAX
        || TIMEOUT_CYCLES == 1) begin : g_bad_cfg
        $error("rvx_wb_bridge: illegal parameter combination");
    end

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [31:0]           cnt;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  active;
    logic                  term_bus;
    logic                  timed_out;
    logic                  term;
    logic                  term_err;
    logic [DATA_WIDTH-1:0] term_data;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;

    assign active   = (state == ISSUE) || (state == WAIT);
    // An ack/err during a stalled strobe does not belong to this transfer.
    assign term_bus = ((state == ISSUE && !wb_stall_i) || state == WAIT)
                      && (wb_ack_i || wb_err_i);
    assign timed_out = (TIMEOUT_CYCLES != 0) && active
                       && (cnt == TO_LAST) && !term_bus;
    assign term      = term_bus || timed_out;
    assign term_err  = timed_out || (term_bus && wb_err_i);
    assign term_data = (term_bus && wb_ack_i && !wb_err_i) ? wb_dat_i : '0;

    resp_pipe #(
        .DEPTH (RESP_STAGES),
        .WIDTH (DATA_WIDTH + 2)
    ) u_resp_pipe (
        .clk     (clk_core),
        .rst     (rst_core),
        .bundle  ({term, term_err, term_data}),
        .delayed ({resp_valid, resp_err, resp_data})
    );

    assign core_read_response  = resp_valid && !wb_we_o;
    assign core_write_response = resp_valid && wb_we_o;
    assign core_error          = resp_valid && resp_err;
    assign core_read_data      = core_read_response ? resp_data : rdata_q;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata_q  <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else begin
            if (core_read_response) begin
                rdata_q <= resp_data;
            end
            case (state)
                IDLE: begin
                    if (core_write_request || core_read_request) begin
                        wb_we_o  <= core_write_request;
                        wb_adr_o <= core_address;
                        wb_dat_o <= core_write_data;
                        wb_sel_o <= core_write_strobe;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        cnt      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 32'd1;
                    if (term) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= RESPOND;
                    end else if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (term) begin
                        wb_cyc_o <= 1'b0;
                        state    <= RESPOND;
                    end
                end
                RESPOND: begin
                    // With a zero-depth pipe the pulse already happened.
                    if (resp_valid || RESP_STAGES == 0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
